// File: rtl/hit_manager_pkg.sv
// hit_manager_pkg.sv: shared constants for the hit manager slice.
// Screen geometry, the fight game-state code and hit FSM states.
package hit_manager_pkg;

    localparam logic [9:0] H_LAST = 10'd639;
    localparam logic [9:0] V_LAST = 10'd479;

    localparam logic [3:0] FIGHT_STATE = 4'd1;

    typedef enum logic [1:0] {
        HM_IDLE,
        HM_FIGHT,
        HM_INVULN,
        HM_DEAD
    } hm_state_t;

endpackage

// File: rtl/hit_overlap_accum.sv
// hit_overlap_accum.sv: per-bullet sticky overlap mask for one frame.
// merged folds in the current pixel so the last pixel of a frame counts.
module hit_overlap_accum #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [N-1:0] hit,
    output logic [N-1:0] merged
);

    logic [N-1:0] pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else if (clear) begin
            pending <= '0;
        end else begin
            pending <= pending | hit;
        end
    end

    assign merged = pending | hit;

endmodule

// File: rtl/hit_manager.sv
// hit_manager.sv: heart/bullet collision, HP, i-frames and game-over.
// Define HIT_BLINK_EN to blink the heart while invulnerable.
module hit_manager #(
    parameter int NUM_BULLETS = 3,
    parameter int HP_W        = 5,
    parameter int HP_MAX      = 20,
    parameter int DAMAGE      = 4,
    parameter int IFRAMES     = 30
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             state,
    input  logic [9:0]             x,
    input  logic [9:0]             y,
    input  logic                   heart_on,
    input  logic [NUM_BULLETS-1:0] bullet_on,
    output logic [NUM_BULLETS-1:0] collision,
    output logic [HP_W-1:0]        hp,
    output logic                   invuln,
    output logic                   game_over,
    output logic                   heart_visible
);

    import hit_manager_pkg::*;

    localparam int CNT_W = $clog2(IFRAMES + 1);
    localparam logic [HP_W-1:0]  HP_FULL = HP_W'(HP_MAX);
    localparam logic [HP_W-1:0]  DMG     = HP_W'(DAMAGE);
    localparam logic [CNT_W-1:0] IF_LOAD = CNT_W'(IFRAMES);
    localparam logic [CNT_W-1:0] IF_ONE  = CNT_W'(1);

    hm_state_t             fsm;
    logic [CNT_W-1:0]      iframe;
    logic [NUM_BULLETS-1:0] hit;
    logic [NUM_BULLETS-1:0] merged;
    logic [HP_W-1:0]       hp_hit;
    logic                  frame_end;
    logic                  fight_in;
    logic                  active;
    logic                  clear;

    assign frame_end = (x == H_LAST) && (y == V_LAST);
    assign fight_in  = (state == FIGHT_STATE);
    assign active    = fight_in && (fsm == HM_FIGHT || fsm == HM_INVULN);
    assign hit       = (active && heart_on) ? bullet_on : '0;
    assign clear     = !active || frame_end;
    assign hp_hit    = (hp > DMG) ? hp - DMG : '0;

    hit_overlap_accum #(
        .N(NUM_BULLETS)
    ) u_accum (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .hit   (hit),
        .merged(merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm       <= HM_IDLE;
            hp        <= HP_FULL;
            collision <= '0;
            game_over <= 1'b0;
            iframe    <= '0;
        end else begin
            collision <= '0;
            if (!fight_in) begin
                // leaving the fight wins over any frame-end damage
                fsm    <= HM_IDLE;
                iframe <= '0;
            end else begin
                unique case (fsm)
                    HM_IDLE: begin
                        fsm <= HM_FIGHT;
                        hp  <= HP_FULL;
                    end
                    HM_FIGHT: begin
                        if (frame_end && |merged) begin
                            hp        <= hp_hit;
                            collision <= merged;
                            iframe    <= IF_LOAD;
                            if (hp_hit == '0) begin
                                fsm       <= HM_DEAD;
                                game_over <= 1'b1;
                            end else begin
                                fsm <= HM_INVULN;
                            end
                        end
                    end
                    HM_INVULN: begin
                        if (frame_end) begin
                            iframe <= iframe - IF_ONE;
                            if (iframe == IF_ONE) begin
                                fsm <= HM_FIGHT;
                            end
                        end
                    end
                    HM_DEAD: begin
                        game_over <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign invuln = (fsm == HM_INVULN);

`ifdef HIT_BLINK_EN
    assign heart_visible = (fsm == HM_DEAD)   ? 1'b0 :
                           (fsm == HM_INVULN) ? iframe[2] : 1'b1;
`else
    assign heart_visible = (fsm != HM_DEAD);
`endif

endmodule

// File: tb/tb_hit_manager.sv
// tb_hit_manager.sv: self-checking bench for hit_manager.
// Directed table, hand sequences and random frames against a rule model.
module tb_hit_manager;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] state;
    logic [9:0] x;
    logic [9:0] y;
    logic       heart_on;
    logic [2:0] bullet_on;
    logic [2:0] collision;
    logic [4:0] hp;
    logic       invuln;
    logic       game_over;
    logic       heart_visible;

    int checks = 0;
    int failures = 0;

    localparam int M_IDLE   = 0;
    localparam int M_FIGHT  = 1;
    localparam int M_INVULN = 2;
    localparam int M_DEAD   = 3;

    int m_mode, m_hp, m_left, m_pend, m_col, m_go;

    typedef struct {
        logic [3:0] st;
        logic       ho;
        logic [2:0] bo;
        logic       fe;
        int         col;
        int         hpv;
        int         inv;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    hit_manager dut (
        .clk          (clk),
        .reset        (reset),
        .state        (state),
        .x            (x),
        .y            (y),
        .heart_on     (heart_on),
        .bullet_on    (bullet_on),
        .collision    (collision),
        .hp           (hp),
        .invuln       (invuln),
        .game_over    (game_over),
        .heart_visible(heart_visible)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_hp   = 20;
        m_left = 0;
        m_pend = 0;
        m_col  = 0;
        m_go   = 0;
    endtask

    // One clock edge of game rules: hits gathered over a frame are judged at its last pixel
    task automatic model_edge(input int st, input int ho, input int bo, input int fe);
        int seen;
        m_col = 0;
        if (st != 1) begin
            m_mode = M_IDLE;
            m_pend = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_FIGHT;
            m_hp   = 20;
            m_pend = 0;
        end else if (m_mode != M_DEAD) begin
            seen = m_pend | (ho != 0 ? bo : 0);
            if (fe == 0) begin
                m_pend = seen;
            end else begin
                m_pend = 0;
                if (m_mode == M_INVULN) begin
                    m_left--;
                    if (m_left == 0) m_mode = M_FIGHT;
                end else if (seen != 0) begin
                    m_col  = seen;
                    m_hp   = (m_hp > 4) ? m_hp - 4 : 0;
                    m_left = 30;
                    if (m_hp == 0) begin
                        m_mode = M_DEAD;
                        m_go   = 1;
                    end else begin
                        m_mode = M_INVULN;
                    end
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".collision"}, int'(collision), m_col);
        chk({tag, ".hp"}, int'(hp), m_hp);
        chk({tag, ".invuln"}, int'(invuln), int'(m_mode == M_INVULN));
        chk({tag, ".game_over"}, int'(game_over), m_go);
        chk({tag, ".visible"}, int'(heart_visible), int'(m_mode != M_DEAD));
    endtask

    task automatic step(input logic [3:0] st, input logic ho,
                        input logic [2:0] bo, input logic fe);
        state     = st;
        heart_on  = ho;
        bullet_on = bo;
        if (fe) begin
            x = 10'd639;
            y = 10'd479;
        end else if ($urandom_range(0, 3) == 0) begin
            x = 10'd639;
            y = 10'($urandom_range(0, 478));
        end else begin
            x = 10'($urandom_range(0, 638));
            y = 10'($urandom_range(0, 479));
        end
        @(posedge clk);
        #1;
        model_edge(int'(st), int'(ho), int'(bo), int'(fe));
        compare_all("step");
    endtask

    task automatic frame(input logic [3:0] st, input logic [2:0] ovl, input logic at_end);
        step(st, !at_end && (ovl != 3'b000), ovl, 1'b0);
        step(st, 1'b0, 3'b000, 1'b0);
        step(st, at_end, ovl, 1'b1);
    endtask

    task automatic quiet_frames(input int n);
        for (int k = 0; k < n; k++) frame(4'd1, 3'b000, 1'b0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        model_reset();
        chk("areset.hp", int'(hp), 20);
        chk("areset.collision", int'(collision), 0);
        chk("areset.game_over", int'(game_over), 0);
        chk("areset.invuln", int'(invuln), 0);
        chk("areset.visible", int'(heart_visible), 1);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        tbl[0] = '{4'd0, 1'b0, 3'b000, 1'b0, 0, 20, 0};
        tbl[1] = '{4'd1, 1'b0, 3'b000, 1'b0, 0, 20, 0};
        tbl[2] = '{4'd1, 1'b1, 3'b000, 1'b0, 0, 20, 0};
        tbl[3] = '{4'd1, 1'b0, 3'b111, 1'b0, 0, 20, 0};
        tbl[4] = '{4'd1, 1'b0, 3'b000, 1'b1, 0, 20, 0};
        tbl[5] = '{4'd1, 1'b1, 3'b010, 1'b0, 0, 20, 0};
        tbl[6] = '{4'd1, 1'b0, 3'b000, 1'b1, 2, 16, 1};
        tbl[7] = '{4'd1, 1'b0, 3'b000, 1'b0, 0, 16, 1};

        reset     = 1'b1;
        state     = 4'd0;
        x         = 10'd0;
        y         = 10'd0;
        heart_on  = 1'b0;
        bullet_on = 3'b000;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset.hp", int'(hp), 20);
        chk("reset.collision", int'(collision), 0);
        chk("reset.game_over", int'(game_over), 0);
        chk("reset.invuln", int'(invuln), 0);
        chk("reset.visible", int'(heart_visible), 1);
        reset = 1'b0;
        #1;

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].st, tbl[i].ho, tbl[i].bo, tbl[i].fe);
            chk($sformatf("vec%0d.collision", i), int'(collision), tbl[i].col);
            chk($sformatf("vec%0d.hp", i), int'(hp), tbl[i].hpv);
            chk($sformatf("vec%0d.invuln", i), int'(invuln), tbl[i].inv);
        end

        for (int i = 1; i <= 30; i++) begin
            frame(4'd1, 3'b001, 1'b0);
            if (i == 29) chk("iframes.still_invuln", int'(invuln), 1);
        end
        chk("iframes.hp_held", int'(hp), 16);
        chk("iframes.invuln_drop", int'(invuln), 0);

        frame(4'd1, 3'b101, 1'b0);
        chk("dual.collision", int'(collision), 5);
        chk("dual.hp", int'(hp), 12);
        step(4'd1, 1'b0, 3'b000, 1'b0);
        chk("dual.pulse_one_cycle", int'(collision), 0);

        quiet_frames(30);
        frame(4'd1, 3'b010, 1'b1);
        chk("lastpix.collision", int'(collision), 2);
        chk("lastpix.hp", int'(hp), 8);

        pulse_reset();

        step(4'd1, 1'b0, 3'b000, 1'b0);
        frame(4'd1, 3'b100, 1'b0);
        chk("abort.pre_hp", int'(hp), 16);
        quiet_frames(30);
        step(4'd1, 1'b1, 3'b100, 1'b0);
        step(4'd0, 1'b0, 3'b000, 1'b1);
        chk("abort.collision", int'(collision), 0);
        chk("abort.hp", int'(hp), 16);
        step(4'd1, 1'b0, 3'b000, 1'b0);
        chk("abort.reload", int'(hp), 20);

        for (int k = 0; k < 5; k++) begin
            frame(4'd1, 3'b001, 1'b0);
            if (k < 4) quiet_frames(30);
        end
        chk("death.hp", int'(hp), 0);
        chk("death.game_over", int'(game_over), 1);
        chk("death.visible", int'(heart_visible), 0);
        for (int k = 0; k < 3; k++) begin
            frame(4'd1, 3'b111, 1'b0);
            chk("dead.no_pulse", int'(collision), 0);
        end
        chk("dead.no_wrap", int'(hp), 0);
        step(4'd0, 1'b0, 3'b000, 1'b0);
        chk("dead.exit_sticky", int'(game_over), 1);
        step(4'd1, 1'b0, 3'b000, 1'b0);
        chk("dead.reload", int'(hp), 20);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 799) == 0) begin
                pulse_reset();
            end else begin
                step(($urandom_range(0, 39) == 0) ? 4'($urandom_range(0, 3)) : 4'd1,
                     1'($urandom_range(0, 1)),
                     3'($urandom_range(0, 7)),
                     ($urandom_range(0, 3) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
